// File: rtl/axi_dw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_dw_pkg
// Brief    : Shared slot-state encoding and beat-count helper for the
//            AXI data-width read scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package axi_dw_pkg;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_ISSUE = 2'd1,
        SLOT_BUSY  = 2'd2
    } slot_state_e;

    // Narrow bursts smaller than a manager beat still cost one beat each.
    function automatic logic [31:0] beat_count(input logic [7:0]  len,
                                               input logic [2:0]  size,
                                               input int unsigned mgr_bytes);
        logic [31:0] ratio;
        ratio = (32'd1 << size) / mgr_bytes;
        if (ratio == 32'd0) begin
            ratio = 32'd1;
        end
        return ({24'd0, len} + 32'd1) * ratio;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_dw_rd_slot.sv
`default_nettype none
// ============================================================================
// Module   : axi_dw_rd_slot
// Brief    : One read tracking slot: IDLE -> ISSUE -> BUSY -> IDLE, with a
//            countdown of expected manager-side R beats.
// Revision : 1.0 - initial release
// ============================================================================
module axi_dw_rd_slot
    import axi_dw_pkg::*;
#(
    parameter int unsigned IdWidth = 1,
    parameter int unsigned BeatW   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_alloc,
    input  logic [IdWidth-1:0] i_alloc_id,
    input  logic [BeatW-1:0]   i_alloc_beats,
    input  logic               i_issued,
    input  logic               i_beat,
    output logic [1:0]         o_state,
    output logic [IdWidth-1:0] o_id,
    output logic               o_final
);

    localparam logic [1:0] c_idle  = SLOT_IDLE;
    localparam logic [1:0] c_issue = SLOT_ISSUE;
    localparam logic [1:0] c_busy  = SLOT_BUSY;

    logic [1:0]         r_state;
    logic [IdWidth-1:0] r_id;
    logic [BeatW-1:0]   r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_id    <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (i_alloc) begin
                        r_state <= c_issue;
                        r_id    <= i_alloc_id;
                        r_cnt   <= i_alloc_beats;
                    end
                end
                c_issue: begin
                    if (i_issued) begin
                        r_state <= c_busy;
                    end
                end
                c_busy: begin
                    if (i_beat) begin
                        r_cnt <= r_cnt - BeatW'(1);
                        if (r_cnt == BeatW'(1)) begin
                            r_state <= c_idle;
                        end
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign o_state = r_state;
    assign o_id    = r_id;
    assign o_final = (r_cnt == BeatW'(1));

endmodule
`default_nettype wire

// File: rtl/lzc.sv
`default_nettype none
// ============================================================================
// Module   : lzc
// Brief    : Leading/trailing zero counter (common-cells compatible ports).
// Revision : 1.0 - initial release
// ============================================================================
module lzc #(
    parameter int unsigned WIDTH = 2,
    parameter bit          MODE  = 1'b0,
    localparam int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    always_comb begin
        cnt_o   = '0;
        empty_o = ~|in_i;
        if (!MODE) begin
            for (int k = int'(WIDTH) - 1; k >= 0; k--) begin
                if (in_i[k]) begin
                    cnt_o = CNT_WIDTH'(k);
                end
            end
        end else begin
            for (int k = 0; k < int'(WIDTH); k++) begin
                if (in_i[k]) begin
                    cnt_o = CNT_WIDTH'(int'(WIDTH) - 1 - k);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_dw_rd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : axi_dw_rd_scheduler
// Brief    : Tracks outstanding read bursts across a data-width downsizer,
//            issuing one AR at a time and counting manager-side R beats.
// Revision : 1.0 - initial release
// ============================================================================
module axi_dw_rd_scheduler
    import axi_dw_pkg::*;
#(
    parameter int unsigned MaxReads         = 2,
    parameter int unsigned IdWidth          = 1,
    parameter int unsigned SbrPortDataWidth = 64,
    parameter int unsigned MgrPortDataWidth = 32,
    localparam int unsigned c_slot_w = (MaxReads > 1) ? $clog2(MaxReads) : 1,
    localparam int unsigned c_beat_w =
        $clog2(256 * SbrPortDataWidth / MgrPortDataWidth) + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ar_valid_i,
    output logic                ar_ready_o,
    input  logic [IdWidth-1:0]  ar_id_i,
    input  logic [7:0]          ar_len_i,
    input  logic [2:0]          ar_size_i,
    output logic                ar_valid_o,
    input  logic                ar_ready_i,
    output logic [IdWidth-1:0]  ar_id_o,
    output logic [c_slot_w-1:0] ar_slot_o,
    output logic [c_beat_w-1:0] ar_beats_o,
    input  logic                r_valid_i,
    input  logic                r_ready_i,
    input  logic [IdWidth-1:0]  r_id_i,
    input  logic                r_last_i,
    output logic                r_hit_o,
    output logic [c_slot_w-1:0] r_slot_o,
    output logic [MaxReads-1:0] busy_o,
    output logic                err_o
);

    localparam int unsigned c_mgr_bytes = MgrPortDataWidth / 8;
    localparam logic [2:0]  c_max_size  = 3'($clog2(SbrPortDataWidth / 8));

    logic [1:0]         w_state   [MaxReads];
    logic [IdWidth-1:0] w_slot_id [MaxReads];
    logic [MaxReads-1:0] w_final, w_idle, w_issue, w_busy;
    logic [MaxReads-1:0] w_id_used, w_match, w_alloc, w_issued, w_beat;
    logic [c_slot_w-1:0] w_free_slot;
    logic                w_none_free;
    logic                w_ar_fire, w_r_fire, w_hit, w_hit_final, w_err;
    logic [c_beat_w-1:0] w_ar_beats;

    logic                r_ar_valid;
    logic [IdWidth-1:0]  r_ar_id;
    logic [c_slot_w-1:0] r_ar_slot;
    logic [c_beat_w-1:0] r_ar_beats;
    logic                r_err;

    for (genvar i = 0; i < MaxReads; i++) begin : g_slot
        assign w_idle[i]    = (w_state[i] == SLOT_IDLE);
        assign w_issue[i]   = (w_state[i] == SLOT_ISSUE);
        assign w_busy[i]    = (w_state[i] == SLOT_BUSY);
        assign w_id_used[i] = !w_idle[i] && (w_slot_id[i] == ar_id_i);
        assign w_match[i]   = w_busy[i] && (w_slot_id[i] == r_id_i);
        assign w_alloc[i]   = w_ar_fire && (w_free_slot == c_slot_w'(i));
        assign w_issued[i]  = r_ar_valid && ar_ready_i && (r_ar_slot == c_slot_w'(i));
        assign w_beat[i]    = w_r_fire && w_match[i];

        axi_dw_rd_slot #(
            .IdWidth (IdWidth),
            .BeatW   (c_beat_w)
        ) u_slot (
            .clk           (clk_i),
            .rst           (rst_i),
            .i_alloc       (w_alloc[i]),
            .i_alloc_id    (ar_id_i),
            .i_alloc_beats (w_ar_beats),
            .i_issued      (w_issued[i]),
            .i_beat        (w_beat[i]),
            .o_state       (w_state[i]),
            .o_id          (w_slot_id[i]),
            .o_final       (w_final[i])
        );
    end

    lzc #(
        .WIDTH (MaxReads),
        .MODE  (1'b0)
    ) u_free_lzc (
        .in_i    (w_idle),
        .cnt_o   (w_free_slot),
        .empty_o (w_none_free)
    );

    // The ISSUE slot hands off in the same cycle a new AR takes its place.
    assign ar_ready_o = !w_none_free && !(|w_id_used) && (!(|w_issue) || ar_ready_i);
    assign w_ar_fire  = ar_valid_i && ar_ready_o;
    assign w_ar_beats = c_beat_w'(beat_count(ar_len_i, ar_size_i, c_mgr_bytes));

    assign w_r_fire    = r_valid_i && r_ready_i;
    assign w_hit       = |w_match;
    assign w_hit_final = |(w_match & w_final);
    assign w_err       = (w_r_fire && (!w_hit || (r_last_i != w_hit_final)))
                       || (w_ar_fire && (ar_size_i > c_max_size));

    always_comb begin
        r_slot_o = '0;
        for (int k = 0; k < int'(MaxReads); k++) begin
            if (w_match[k]) begin
                r_slot_o = c_slot_w'(k);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ar_valid <= 1'b0;
            r_ar_id    <= '0;
            r_ar_slot  <= '0;
            r_ar_beats <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_err;
            if (w_ar_fire) begin
                r_ar_valid <= 1'b1;
                r_ar_id    <= ar_id_i;
                r_ar_slot  <= w_free_slot;
                r_ar_beats <= w_ar_beats;
            end else if (ar_ready_i) begin
                r_ar_valid <= 1'b0;
            end
        end
    end

    assign ar_valid_o = r_ar_valid;
    assign ar_id_o    = r_ar_id;
    assign ar_slot_o  = r_ar_slot;
    assign ar_beats_o = r_ar_beats;
    assign r_hit_o    = w_r_fire && w_hit;
    assign busy_o     = w_issue | w_busy;
    assign err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_dw_rd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_dw_rd_scheduler
// Brief    : Directed vector bench for the AXI read scheduler (64->32, 2 slots).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_dw_rd_scheduler;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       ar_valid_i = 1'b0, ar_ready_i = 1'b0;
    logic [1:0] ar_id_i = '0;
    logic [7:0] ar_len_i = '0;
    logic [2:0] ar_size_i = '0;
    logic       r_valid_i = 1'b0, r_ready_i = 1'b0, r_last_i = 1'b0;
    logic [1:0] r_id_i = '0;
    logic       ar_ready_o, ar_valid_o, r_hit_o, err_o;
    logic [1:0] ar_id_o, busy_o;
    logic [0:0] ar_slot_o, r_slot_o;
    logic [9:0] ar_beats_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi_dw_rd_scheduler #(
        .MaxReads         (2),
        .IdWidth          (2),
        .SbrPortDataWidth (64),
        .MgrPortDataWidth (32)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .ar_valid_i (ar_valid_i),
        .ar_ready_o (ar_ready_o),
        .ar_id_i    (ar_id_i),
        .ar_len_i   (ar_len_i),
        .ar_size_i  (ar_size_i),
        .ar_valid_o (ar_valid_o),
        .ar_ready_i (ar_ready_i),
        .ar_id_o    (ar_id_o),
        .ar_slot_o  (ar_slot_o),
        .ar_beats_o (ar_beats_o),
        .r_valid_i  (r_valid_i),
        .r_ready_i  (r_ready_i),
        .r_id_i     (r_id_i),
        .r_last_i   (r_last_i),
        .r_hit_o    (r_hit_o),
        .r_slot_o   (r_slot_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    typedef struct {
        logic [7:0] len;
        logic [2:0] size;
        int         beats;
        logic       err;
    } vec_t;

    vec_t vecs [7];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        ar_valid_i = 1'b0; ar_ready_i = 1'b0;
        r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
        cyc();
        rst_i = 1'b0;
    endtask

    task automatic ar_send(input logic [1:0] id, input logic [7:0] len, input logic [2:0] size);
        ar_valid_i = 1'b1; ar_id_i = id; ar_len_i = len; ar_size_i = size;
        #1;
        chk("ar_ready_on_send", 32'(ar_ready_o), 32'd1);
        cyc();
        ar_valid_i = 1'b0;
    endtask

    task automatic r_beat(input logic [1:0] id, input logic last);
        r_valid_i = 1'b1; r_ready_i = 1'b1; r_id_i = id; r_last_i = last;
        cyc();
        r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
    endtask

    task automatic issue_done();
        ar_ready_i = 1'b1;
        cyc();
        ar_ready_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int errs;
        int nb;
        int stalls;
        vecs[0] = '{len: 8'd3,   size: 3'd3, beats: 8,   err: 1'b0};
        vecs[1] = '{len: 8'd0,   size: 3'd2, beats: 1,   err: 1'b0};
        vecs[2] = '{len: 8'd0,   size: 3'd0, beats: 1,   err: 1'b0};
        vecs[3] = '{len: 8'd1,   size: 3'd1, beats: 2,   err: 1'b0};
        vecs[4] = '{len: 8'd2,   size: 3'd3, beats: 6,   err: 1'b0};
        vecs[5] = '{len: 8'd0,   size: 3'd4, beats: 4,   err: 1'b1};
        vecs[6] = '{len: 8'd255, size: 3'd2, beats: 256, err: 1'b0};

        do_reset();
        chk("rst_ar_ready",   32'(ar_ready_o), 32'd1);
        chk("rst_ar_valid",   32'(ar_valid_o), 32'd0);
        chk("rst_busy",       32'(busy_o),     32'd0);
        chk("rst_err",        32'(err_o),      32'd0);
        chk("rst_ar_beats",   32'(ar_beats_o), 32'd0);

        for (int i = 0; i < 7; i++) begin
            nb = vecs[i].beats;
            ar_send(2'd0, vecs[i].len, vecs[i].size);
            chk("vec_ar_valid", 32'(ar_valid_o), 32'd1);
            chk("vec_ar_beats", 32'(ar_beats_o), 32'(nb));
            chk("vec_ar_slot",  32'(ar_slot_o),  32'd0);
            chk("vec_err_ar",   32'(err_o),      32'(vecs[i].err));
            chk("vec_busy_iss", 32'(busy_o),     32'd1);
            issue_done();
            chk("vec_ar_drop",  32'(ar_valid_o), 32'd0);
            errs = 0;
            for (int b = 1; b <= nb; b++) begin
                r_beat(2'd0, b == nb);
                errs += int'(err_o);
            end
            chk("vec_busy_free", 32'(busy_o), 32'd0);
            chk("vec_r_errs",    32'(errs),   32'd0);
        end

        // Same-ID AR stalls until the cycle after the final R beat.
        do_reset();
        ar_send(2'd0, 8'd3, 3'd3);
        ar_valid_i = 1'b1; ar_id_i = 2'd0;
        issue_done();
        stalls = 0;
        for (int b = 1; b <= 8; b++) begin
            r_valid_i = 1'b1; r_ready_i = 1'b1; r_id_i = 2'd0; r_last_i = (b == 8);
            #1;
            if (b == 1) chk("same_id_hit", 32'(r_hit_o), 32'd1);
            stalls += int'(ar_ready_o);
            cyc();
        end
        r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
        chk("same_id_stalled", 32'(stalls), 32'd0);
        #1;
        chk("same_id_ready_after", 32'(ar_ready_o), 32'd1);
        cyc();
        ar_valid_i = 1'b0;
        chk("same_id_reissue", 32'(ar_valid_o), 32'd1);
        chk("same_id_slot",    32'(ar_slot_o),  32'd0);

        // Both slots full; third ID waits, then takes the freed slot.
        do_reset();
        ar_send(2'd0, 8'd0, 3'd2);
        ar_valid_i = 1'b1; ar_id_i = 2'd1; ar_ready_i = 1'b1;
        #1;
        chk("full_handoff_ready", 32'(ar_ready_o), 32'd1);
        cyc();
        chk("full_id1_valid", 32'(ar_valid_o), 32'd1);
        chk("full_id1_id",    32'(ar_id_o),    32'd1);
        chk("full_id1_slot",  32'(ar_slot_o),  32'd1);
        ar_id_i = 2'd2;
        #1;
        chk("full_id2_stall", 32'(ar_ready_o), 32'd0);
        cyc();
        ar_ready_i = 1'b0;
        chk("full_busy", 32'(busy_o), 32'd3);
        chk("full_ar_drop", 32'(ar_valid_o), 32'd0);
        r_valid_i = 1'b1; r_ready_i = 1'b1; r_id_i = 2'd1; r_last_i = 1'b1;
        #1;
        chk("full_id2_stall2", 32'(ar_ready_o), 32'd0);
        chk("full_r_hit",      32'(r_hit_o),    32'd1);
        chk("full_r_slot1",    32'(r_slot_o),   32'd1);
        cyc();
        r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
        chk("full_busy_after", 32'(busy_o), 32'd1);
        chk("full_ready_free", 32'(ar_ready_o), 32'd1);
        cyc();
        ar_valid_i = 1'b0;
        chk("full_id2_slot", 32'(ar_slot_o), 32'd1);
        chk("full_id2_id",   32'(ar_id_o),   32'd2);
        issue_done();
        r_valid_i = 1'b1; r_ready_i = 1'b1; r_id_i = 2'd0; r_last_i = 1'b1;
        #1;
        chk("full_r_slot0", 32'(r_slot_o), 32'd0);
        cyc();
        r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
        chk("full_err_none", 32'(err_o), 32'd0);

        // Protocol errors: stray R, early last, missing last.
        do_reset();
        r_valid_i = 1'b1; r_ready_i = 1'b1; r_id_i = 2'd1; r_last_i = 1'b0;
        #1;
        chk("stray_hit", 32'(r_hit_o), 32'd0);
        cyc();
        r_valid_i = 1'b0; r_ready_i = 1'b0;
        chk("stray_err", 32'(err_o), 32'd1);
        cyc();
        chk("stray_err_pulse", 32'(err_o), 32'd0);
        chk("stray_busy", 32'(busy_o), 32'd0);
        ar_send(2'd0, 8'd3, 3'd3);
        issue_done();
        for (int b = 1; b <= 8; b++) begin
            r_beat(2'd0, (b == 5) || (b == 8));
            if (b == 5) chk("early_last_err", 32'(err_o), 32'd1);
            if (b == 6) chk("early_last_pulse", 32'(err_o), 32'd0);
        end
        chk("early_last_freed", 32'(busy_o), 32'd0);
        ar_send(2'd1, 8'd0, 3'd2);
        issue_done();
        r_beat(2'd1, 1'b0);
        chk("no_last_err",   32'(err_o),  32'd1);
        chk("no_last_freed", 32'(busy_o), 32'd0);

        // Reset mid-burst with a second AR still waiting downstream.
        do_reset();
        ar_send(2'd0, 8'd3, 3'd3);
        issue_done();
        for (int b = 1; b <= 3; b++) r_beat(2'd0, 1'b0);
        ar_send(2'd1, 8'd0, 3'd2);
        chk("mid_pre_busy", 32'(busy_o), 32'd3);
        do_reset();
        chk("mid_busy",     32'(busy_o),     32'd0);
        chk("mid_ar_valid", 32'(ar_valid_o), 32'd0);
        chk("mid_ar_ready", 32'(ar_ready_o), 32'd1);
        chk("mid_ar_beats", 32'(ar_beats_o), 32'd0);
        chk("mid_err",      32'(err_o),      32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
